// File: rtl/nf10_arb_pkg.sv
// Shared types and helpers for the packet round-robin input arbiter.
package nf10_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index width for NUM_INPUTS requesters; never narrower than 1 bit.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nf10_axis_skid_reg.sv
// Two-entry register slice; out_ready has no combinational path to not_full.
module nf10_axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         not_full,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [W-1:0] tail;
  logic [1:0]   cnt, cnt_nxt;
  logic         push, pop;

  assign push      = in_valid & not_full;
  assign pop       = out_valid & out_ready;
  assign out_valid = (cnt != 2'd0);

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 2'd1;
    else if (pop && !push) cnt_nxt = cnt - 2'd1;
  end

  // not_full is low only while both entries are held, so a push never lands on cnt==2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      not_full <= 1'b1;
      out_data <= '0;
      tail     <= '0;
    end else begin
      cnt      <= cnt_nxt;
      not_full <= (cnt_nxt != 2'd2);
      if (pop && cnt == 2'd2)                      out_data <= tail;
      else if (push && (cnt == 2'd0 || pop))       out_data <= in_data;
      if (push && cnt == 2'd1 && !pop)             tail     <= in_data;
    end
  end

endmodule

// File: rtl/nf10_input_arbiter_rr.sv
// Packet-granular round-robin merge of NUM_INPUTS AXI4-Stream ports into one,
// registered through a 2-entry skid so m_axis_tready never reaches s_axis_tready.
module nf10_input_arbiter_rr
  import nf10_arb_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_USER_WIDTH      = 128,
  parameter int NUM_INPUTS        = 5
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_reset,
  input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [NUM_INPUTS*C_USER_WIDTH-1:0]          s_axis_tuser,
  input  logic [NUM_INPUTS-1:0]                       s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]                       s_axis_tlast,
  output logic [NUM_INPUTS-1:0]                       s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic [C_USER_WIDTH-1:0]                     m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_USER_WIDTH;
  localparam int N  = NUM_INPUTS;
  localparam int PW = log2(NUM_INPUTS);
  localparam int W  = DW + SW + UW + 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt, grant, grant_nxt, sel;
  logic [PW:0]     sum;
  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic            found, skid_not_full, accept, cur_valid, cur_last;
  logic [W-1:0]    cur_beat, m_beat;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the next winner.
  assign req_dbl = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    found = 1'b0;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (PW+1)'(k);
      end
    end
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    sel = sum[PW-1:0];
  end

  always_comb begin
    cur_beat = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == PW'(i))
        cur_beat = {s_axis_tdata[i*DW +: DW], s_axis_tstrb[i*SW +: SW],
                    s_axis_tuser[i*UW +: UW], s_axis_tlast[i]};
    end
  end

  assign cur_valid = s_axis_tvalid[grant];
  assign cur_last  = cur_beat[0];
  assign accept    = (state == SEND) & cur_valid & skid_not_full;

  always_comb begin
    s_axis_tready = '0;
    if (state == SEND) s_axis_tready[grant] = skid_not_full;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: if (found) begin
        state_nxt = SEND;
        grant_nxt = sel;
      end
      SEND: if (accept && cur_last) begin
        state_nxt = IDLE;
        rr_nxt    = (grant == PW'(N - 1)) ? '0 : grant + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      grant  <= grant_nxt;
    end
  end

  nf10_axis_skid_reg #(.W(W)) u_skid (
    .clk       (axi_aclk),
    .rst       (axi_reset),
    .in_valid  (accept),
    .in_data   (cur_beat),
    .not_full  (skid_not_full),
    .out_valid (m_axis_tvalid),
    .out_data  (m_beat),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = m_beat;

endmodule

// File: tb/tb_nf10_input_arbiter_rr.sv
// Scoreboard bench for nf10_input_arbiter_rr: per-input beat queues, packet order queue,
// per-input drivers and one output monitor.
module tb_nf10_input_arbiter_rr;

  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;
  localparam int N  = 5;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
    int            gap;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  [N*DW-1:0] s_tdata;
  wire  [N*SW-1:0] s_tstrb;
  wire  [N*UW-1:0] s_tuser;
  wire  [N-1:0]    s_tvalid, s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid, m_tlast;
  logic            m_tready = 1'b0;

  beat_t pend  [N][$];
  beat_t exp_q [N][$];
  int    ord_q[$];
  int    acc_cyc[$];
  int    acc_cnt [N];
  int    seq [N];
  int    total = 0, bad = 0, starts = 0, cyc = 0, mr_mode = 0;
  bit    log_acc = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nf10_input_arbiter_rr #(.C_AXIS_DATA_WIDTH(DW), .C_USER_WIDTH(UW), .NUM_INPUTS(N)) dut (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready)
  );

  // Per-input driver: handshakes resolved at negedge, new values driven 1 time unit later.
  for (genvar g = 0; g < N; g++) begin : drv
    logic [DW-1:0] d  = '0;
    logic [SW-1:0] st = '0;
    logic [UW-1:0] u  = '0;
    logic          v  = 1'b0;
    logic          l  = 1'b0;
    assign s_tdata[g*DW +: DW] = d;
    assign s_tstrb[g*SW +: SW] = st;
    assign s_tuser[g*UW +: UW] = u;
    assign s_tvalid[g]         = v;
    assign s_tlast[g]          = l;

    initial begin
      beat_t cur;
      bit pres, rdy, first;
      int gapc, mark;
      pres = 0; rdy = 0; first = 1; gapc = 0; mark = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          pres = 0; first = 1; gapc = 0;
        end else if (pres && rdy) begin
          if (first) begin
            total++;
            if (starts - mark > N - 1) begin
              bad++;
              $display("FAIL fairness in%0d: waited=%0d packets, max=%0d", g, starts - mark, N - 1);
            end
            starts++;
          end
          acc_cnt[g]++;
          if (log_acc) acc_cyc.push_back(cyc);
          first = cur.last;
          pres  = 0;
        end
        #1;
        if (!pres && !rst && pend[g].size() > 0) begin
          if (gapc < pend[g][0].gap) gapc++;
          else begin
            cur  = pend[g].pop_front();
            pres = 1; gapc = 0;
            if (first) mark = starts;
          end
        end
        v = pres;
        if (pres) begin d = cur.data; st = cur.strb; u = cur.user; l = cur.last; end
        rdy = s_tready[g];
      end
    end
  end

  // Output monitor: drives m_tready and checks every accepted output beat.
  initial begin
    bit mv, mr, in_pkt, ml;
    int cur_src, src, o;
    logic [DW-1:0] md;
    logic [SW-1:0] ms;
    logic [UW-1:0] mu;
    beat_t e;
    mv = 0; mr = 0; in_pkt = 0; ml = 0; cur_src = 0; md = '0; ms = '0; mu = '0;
    forever begin
      @(negedge clk);
      if (rst) in_pkt = 0;
      else if (mv && mr) begin
        src = int'(md[31:24]);
        if (!in_pkt && ord_q.size() > 0) begin
          o = ord_q.pop_front();
          total++;
          if (o != src) begin bad++; $display("FAIL order: got src=%0d want src=%0d", src, o); end
        end
        if (in_pkt) begin
          total++;
          if (src != cur_src) begin bad++; $display("FAIL interleave: got src=%0d want src=%0d", src, cur_src); end
        end
        total++;
        if (src >= N) begin
          bad++; $display("FAIL beat: got src=%0d want src<%0d", src, N);
        end else if (exp_q[src].size() == 0) begin
          bad++; $display("FAIL beat: got extra beat id=%h want none from src=%0d", md[31:0], src);
        end else begin
          e = exp_q[src].pop_front();
          if ({md, ms, mu, ml} !== {e.data, e.strb, e.user, e.last}) begin
            bad++;
            $display("FAIL beat src%0d: got id=%h last=%0d want id=%h last=%0d", src, md[31:0], ml, e.data[31:0], e.last);
          end
        end
        in_pkt  = !ml;
        cur_src = src;
      end
      if (!rst) begin
        total++;
        if ($countones(s_tready) > 1) begin bad++; $display("FAIL onehot tready: got %b want at most one bit", s_tready); end
      end
      #1;
      case (mr_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = ($urandom_range(0, 7) != 0);
      endcase
      mv = m_tvalid; mr = m_tready; md = m_tdata; ms = m_tstrb; mu = m_tuser; ml = m_tlast;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin bad++; $display("FAIL %s: got=%0h want=%0h", name, got, want); end
  endtask

  task automatic add_pkt(input int src, input int len, input int gap_beat, input int gap_len, input bit ord);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
      b.strb          = SW'($urandom);
      b.data[31:0]    = {8'(src), 16'(seq[src]), 8'(k)};
      b.last          = (k == len - 1);
      b.gap           = (k == gap_beat) ? gap_len : 0;
      pend[src].push_back(b);
      exp_q[src].push_back(b);
    end
    seq[src]++;
    if (ord) ord_q.push_back(src);
  endtask

  function automatic int left();
    int s;
    s = ord_q.size();
    for (int i = 0; i < N; i++) s += exp_q[i].size() + pend[i].size();
    return s;
  endfunction

  task automatic drain(input string name, input int maxc);
    int c;
    c = 0;
    while (c < maxc && left() != 0) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
    chk({"drain ", name}, 64'(left()), 64'd0);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin pend[i].delete(); exp_q[i].delete(); end
    ord_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #3;
    rst = 1'b1;
    flush();
    @(negedge clk); #3;
    rst = 1'b0;
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, base;
    repeat (3) @(negedge clk);
    #1;
    chk("reset m_tvalid", 64'(m_tvalid), 64'd0);
    chk("reset s_tready", 64'(s_tready), 64'd0);
    #2 rst = 1'b0;

    // Reset in the middle of an 8-beat packet, then a clean 3-beat packet.
    add_pkt(0, 8, -1, 0, 1);
    repeat (5) @(negedge clk);
    #1;
    chk("pre-reset m_tvalid", 64'(m_tvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async m_tvalid", 64'(m_tvalid), 64'd0);
    chk("async m_tlast", 64'(m_tlast), 64'd0);
    chk("async m_tdata", m_tdata[63:0], 64'd0);
    chk("async s_tready", 64'(s_tready), 64'd0);
    flush();
    @(negedge clk); #3;
    rst = 1'b0;
    add_pkt(0, 3, -1, 0, 1);
    drain("t1", 200);

    // All inputs with two 2-beat packets each: 0..4 twice.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) add_pkt(s, 2, -1, 0, 1);
    drain("t2", 400);

    // Input 3 alone with 1-beat packets: one accept every 2 cycles.
    acc_cyc.delete();
    log_acc = 1'b1;
    for (int p = 0; p < 6; p++) add_pkt(3, 1, -1, 0, 1);
    drain("t3", 200);
    log_acc = 1'b0;
    chk("t3 accepts", 64'(acc_cyc.size()), 64'd6);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("t3 accept spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd2);

    // Output stalled for 10 cycles: skid holds exactly 2 beats, input stalls.
    mr_mode = 1;
    base = acc_cnt[0];
    s0   = seq[0];
    add_pkt(0, 6, -1, 0, 1);
    repeat (10) @(negedge clk);
    #2;
    chk("t4 beats taken", 64'(acc_cnt[0] - base), 64'd2);
    chk("t4 s_tready", 64'(s_tready), 64'd0);
    chk("t4 m_tvalid", 64'(m_tvalid), 64'd1);
    chk("t4 head id", 64'(m_tdata[31:0]), 64'({8'd0, 16'(s0), 8'd0}));
    mr_mode = 0;
    drain("t4", 200);

    // Input 1 pauses 4 cycles mid-packet while input 2 waits.
    add_pkt(1, 4, 2, 4, 1);
    add_pkt(2, 2, -1, 0, 1);
    drain("t5", 200);

    // Random traffic, 10k packets, random output backpressure.
    mr_mode = 2;
    for (int p = 0; p < 2000; p++)
      for (int s = 0; s < N; s++)
        add_pkt(s, $urandom_range(1, 3), $urandom_range(0, 7), $urandom_range(1, 3), 0);
    drain("t6", 70000);
    mr_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
